// File: rtl/aes_dr_round_ctrl.sv
// aes_dr_round_ctrl: precharge/evaluate round sequencer for a dual-rail AES-256 datapath.
// Every evaluate cycle is preceded by PRE_CYCLES all-zero precharge cycles; rail faults trap until abort.
module aes_dr_round_ctrl #(
    parameter int NR         = 14,
    parameter int RW         = 4,
    parameter int PRE_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          err_in,
    output logic          precharge,
    output logic          load_in,
    output logic          state_en,
    output logic [RW-1:0] round,
    output logic [RW-1:0] key_sel,
    output logic          skip_mix,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int CW = PRE_CYCLES > 1 ? $clog2(PRE_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, PRE, EVAL, DONE, FAULT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_pre;
    logic          last_round;

    assign last_pre   = cnt == CW'(PRE_CYCLES - 1);
    assign last_round = round == RW'(NR);
    assign key_sel    = round;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            round     <= '0;
            precharge <= 1'b1;
            load_in   <= 1'b0;
            state_en  <= 1'b0;
            skip_mix  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            cnt       <= '0;
            round     <= '0;
            precharge <= 1'b1;
            load_in   <= 1'b0;
            state_en  <= 1'b0;
            skip_mix  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= PRE;
                    cnt   <= '0;
                    round <= '0;
                    busy  <= 1'b1;
                end
                PRE: if (last_pre) begin
                    state     <= EVAL;
                    precharge <= 1'b0;
                    state_en  <= 1'b1;
                    load_in   <= round == '0;
                    skip_mix  <= last_round;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                EVAL: begin
                    state_en  <= 1'b0;
                    load_in   <= 1'b0;
                    skip_mix  <= 1'b0;
                    precharge <= 1'b1;
                    // a rail fault on the final round still beats completion
                    if (err_in) begin
                        state <= FAULT;
                        err   <= 1'b1;
                    end else if (last_round) begin
                        state     <= DONE;
                        precharge <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state <= PRE;
                        cnt   <= '0;
                        round <= round + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    precharge <= 1'b1;
                    round     <= '0;
                end
                FAULT: state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/aes_dr_round_ctrl.md
Name: aes_dr_round_ctrl

Overview:
Round sequencer for the dual-rail (true/false rail) AES-256 datapath: ShiftRows, SubBytes, MixColumns, AddRoundKey and the state register. It enforces the precharge/evaluate discipline so that every evaluate phase starts from an all-zero precharged state. It issues round index, key index and last-round MixColumns bypass, and traps dual-rail integrity faults. It sits between the host start/done interface and the datapath enables.

Parameters:
NR, 14, number of AES rounds (AES-256)
RW, 4, width of round/key index outputs; must satisfy 2^RW > NR
PRE_CYCLES, 1, precharge cycles before each evaluate cycle (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin encryption of the block presented on the datapath input
abort  input  1  terminate any operation, return to IDLE
err_in  input  1  datapath rail checker: 1 = some bit pair has T==F during evaluate
precharge  output  1  1 = datapath drives both rails of every bit to 0
load_in  output  1  state register selects plaintext input (initial AddRoundKey)
state_en  output  1  state register capture enable (evaluate cycles only)
round  output  RW  current round index, 0 = initial key addition
key_sel  output  RW  round-key index to key schedule, equals round
skip_mix  output  1  1 = bypass MixColumns (final round)
busy  output  1  operation in progress (including FAULT)
done  output  1  one-cycle pulse, ciphertext valid on state register
err  output  1  fault flag, held until abort or reset

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; precharge=1, all other outputs 0, round=key_sel=0, internal counters 0.
- All outputs are registered (Moore); no combinational paths from inputs to outputs.
- States: IDLE, PRE, EVAL, DONE, FAULT.
- IDLE: precharge=1, busy=0. start=1 with abort=0 -> PRE, round=0, busy=1.
- PRE: precharge=1, state_en=0, held PRE_CYCLES cycles (precharge counter), then -> EVAL.
- EVAL (one cycle): precharge=0, state_en=1, key_sel=round. round=0: load_in=1. round=NR: skip_mix=1. Otherwise both 0.
- EVAL exit: err_in=1 -> FAULT. Else if round==NR -> DONE. Else round+1, -> PRE.
- DONE (one cycle): done=1, busy=0, precharge=0, state_en=0. Ciphertext remains on the register. -> IDLE (precharge=1 next cycle).
- Latency: start is sampled at edge E0. Working phase occupies cycles 1..(NR+1)*(PRE_CYCLES+1), which is 30 with defaults. done is high in cycle (NR+1)*(PRE_CYCLES+1)+1, which is 31 with defaults.
- FAULT: err=1, busy=1, precharge=1, state_en=0. done is never asserted. Stays until abort.
- err_in is ignored outside EVAL.
- abort=1 in any state: next cycle IDLE, err=0, round=0, counters cleared. abort has priority over start and err_in in the same cycle.
- start while busy or in DONE: ignored, no restart.
- start held high continuously: a new operation begins from IDLE one cycle after DONE, giving back-to-back blocks with one precharged idle cycle between them.
- err_in on the final EVAL (round==NR): FAULT wins, no done.
- Reset mid-operation: immediate IDLE values, no done.
- round never exceeds NR and never wraps.

Test Plan:
- Reset then idle: rst_n low->high, no start -> precharge=1, busy=0, done=0, round=0 for 10 cycles.
- Nominal run, defaults: start pulse at E0 -> state_en high exactly in cycles 2,4,...,30 with round 0..14. load_in only in cycle 2. skip_mix only in cycle 30. precharge=0 only in those cycles and in cycle 31. done=1 in cycle 31 only. busy high cycles 1-30.
- PRE_CYCLES=3: start -> evaluate cycles at 4,8,...,60, done in cycle 61; precharge high for exactly 3 cycles before each evaluate.
- Fault: err_in=1 during round-5 EVAL -> next cycle err=1, precharge=1, busy=1, state_en stays 0. No done within 100 cycles. Then abort -> IDLE, err=0. A following start completes normally.
- Abort mid-run at round 7, start held high, abort simultaneous with start in IDLE -> IDLE held while abort=1. Operation begins on the first cycle abort=0 with start=1. round restarts at 0.
- Back-to-back: start tied high -> done pulses every 32 cycles (defaults). start asserted mid-run causes no disturbance of round sequencing.
